// File: rtl/horner_pkg.sv
// Shared types and defaults for the sequential Horner polynomial evaluator.
package horner_pkg;

  localparam int unsigned HORNER_W       = 32;
  localparam int unsigned HORNER_MAX_DEG = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width of a coefficient index / degree field for a given maximum degree.
  function automatic int unsigned coef_idx_w(input int unsigned max_deg);
    return (max_deg < 1) ? 1 : $clog2(max_deg + 1);
  endfunction

endpackage

// File: rtl/horner_seq_eval_fma.sv
// Combinational a*b+c modulo 2^W; overflow of the full-width result is reported
// only when HORNER_OVF_DETECT_EN is defined, otherwise ovf_o is tied low.
module fma_unit #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] y_o,
  output logic         ovf_o
);

`ifdef HORNER_OVF_DETECT_EN
  logic [2*W:0] full;

  assign full  = (2*W+1)'(a_i) * (2*W+1)'(b_i) + (2*W+1)'(c_i);
  assign y_o   = full[W-1:0];
  assign ovf_o = |full[2*W:W];
`else
  assign y_o   = a_i * b_i + c_i;
  assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/horner_seq_eval.sv
// Sequential Horner evaluator: one acc*x+c[idx] step per cycle from a coefficient store.
// Optional overflow flag enabled by defining HORNER_OVF_DETECT_EN.
module horner_seq_eval
  import horner_pkg::*;
#(
  parameter  int unsigned W       = HORNER_W,
  parameter  int unsigned MAX_DEG = HORNER_MAX_DEG,
  localparam int unsigned DW      = coef_idx_w(MAX_DEG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coef_we,
  input  logic [DW-1:0] coef_addr,
  input  logic [W-1:0]  coef_data,
  input  logic          start,
  output logic          start_ready,
  input  logic [W-1:0]  x_in,
  input  logic [DW-1:0] deg_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic          res_ovf,
  output logic          busy
);

  state_t        state_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  x_q;
  logic [DW-1:0] idx_q;
  logic          ovf_q;
  logic          res_valid_q;
  logic          start_ready_q;
  logic          busy_q;
  logic [W-1:0]  coef_q [MAX_DEG+1];

  logic          ovr_vld_q;
  logic [DW-1:0] ovr_addr_q;
  logic [W-1:0]  ovr_data_q;

  logic          accept;
  logic          addr_ok;
  logic          we_ok;
  logic [DW-1:0] deg_cl;
  logic [W-1:0]  coef_sel;
  logic [W-1:0]  step_res;
  logic          step_ovf;

  if (2**DW == MAX_DEG + 1) begin : g_full_range
    assign addr_ok = 1'b1;
    assign deg_cl  = deg_in;
  end else begin : g_part_range
    assign addr_ok = (coef_addr <= DW'(MAX_DEG));
    assign deg_cl  = (deg_in > DW'(MAX_DEG)) ? DW'(MAX_DEG) : deg_in;
  end

  assign accept = start && (state_q == IDLE);
  assign we_ok  = coef_we && addr_ok && (state_q == IDLE);

  // A write landing on the accept edge must not be seen by this evaluation:
  // the overwritten word is parked and substituted when its index comes up.
  always_comb begin
    coef_sel = coef_q[idx_q];
    if (ovr_vld_q && (ovr_addr_q == idx_q)) coef_sel = ovr_data_q;
  end

  fma_unit #(.W(W)) u_fma (
    .a_i  (acc_q),
    .b_i  (x_q),
    .c_i  (coef_sel),
    .y_o  (step_res),
    .ovf_o(step_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= MAX_DEG; i++) coef_q[i] <= '0;
    end else if (we_ok) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      x_q           <= '0;
      idx_q         <= '0;
      ovf_q         <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      ovr_vld_q     <= 1'b0;
      ovr_addr_q    <= '0;
      ovr_data_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q       <= RUN;
            x_q           <= x_in;
            idx_q         <= deg_cl;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            ovr_vld_q     <= we_ok;
            ovr_addr_q    <= coef_addr;
            ovr_data_q    <= coef_q[coef_addr];
          end
        end
        RUN: begin
          acc_q <= step_res;
          ovf_q <= ovf_q | step_ovf;
          if (idx_q == '0) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
            ovr_vld_q   <= 1'b0;
          end else begin
            idx_q <= idx_q - DW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q       <= IDLE;
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_data    = acc_q;
  assign res_ovf     = ovf_q;

endmodule

// File: tb/tb_horner_seq_eval.sv
// Self-checking bench for horner_seq_eval against a power-sum polynomial model.
module tb_horner_seq_eval;

  localparam int unsigned W       = 32;
  localparam int unsigned MAX_DEG = 7;
  localparam int unsigned DW      = 3;

  logic          clk;
  logic          rst_n;
  logic          coef_we;
  logic [DW-1:0] coef_addr;
  logic [W-1:0]  coef_data;
  logic          start;
  logic          start_ready;
  logic [W-1:0]  x_in;
  logic [DW-1:0] deg_in;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_ovf;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] cm [MAX_DEG+1];

  horner_seq_eval #(.W(W), .MAX_DEG(MAX_DEG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .start      (start),
    .start_ready(start_ready),
    .x_in       (x_in),
    .deg_in     (deg_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_ovf    (res_ovf),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // p(x) = sum c[i]*x^i, modulo 2^W.
  function automatic logic [W-1:0] poly(input logic [W-1:0] x, input int unsigned d);
    logic [W-1:0] sum;
    logic [W-1:0] xp;
    sum = '0;
    xp  = 1;
    for (int unsigned i = 0; i <= d; i++) begin
      sum = sum + cm[i] * xp;
      xp  = xp * x;
    end
    return sum;
  endfunction

  function automatic logic ovf_ref(input logic [W-1:0] x, input int unsigned d);
    logic [2*W:0] full;
    logic [W-1:0] acc;
    logic         f;
    acc = '0;
    f   = 1'b0;
    for (int i = int'(d); i >= 0; i--) begin
      full = (2*W+1)'(acc) * (2*W+1)'(x) + (2*W+1)'(cm[i]);
      if (full > (2*W+1)'({W{1'b1}})) f = 1'b1;
      acc = full[W-1:0];
    end
    return f;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned a, input logic [W-1:0] v);
    coef_we   = 1'b1;
    coef_addr = DW'(a);
    coef_data = v;
    cyc();
    coef_we = 1'b0;
    cm[a]   = v;
  endtask

  task automatic wait_valid(input string tag, input int unsigned exp_lat);
    int unsigned k;
    k = 0;
    while (!res_valid && k < 64) begin
      cyc();
      k++;
    end
    chk({tag, ".lat"}, 64'(k), 64'(exp_lat));
  endtask

  task automatic eval(input string tag, input logic [W-1:0] x, input logic [DW-1:0] d,
                      input bit we, input int unsigned wa, input logic [W-1:0] wv,
                      output logic [W-1:0] got);
    int unsigned  dc;
    logic [W-1:0] er;
    logic         eo;
    dc = (int'(d) > MAX_DEG) ? MAX_DEG : int'(d);
    er = poly(x, dc);
`ifdef HORNER_OVF_DETECT_EN
    eo = ovf_ref(x, dc);
`else
    eo = 1'b0;
`endif
    chk({tag, ".rdy"}, 64'(start_ready), 64'd1);
    start     = 1'b1;
    x_in      = x;
    deg_in    = d;
    coef_we   = we;
    coef_addr = DW'(wa);
    coef_data = wv;
    cyc();
    start   = 1'b0;
    coef_we = 1'b0;
    if (we) cm[wa] = wv;
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    wait_valid(tag, dc + 1);
    got = res_data;
    chk({tag, ".data"}, 64'(res_data), 64'(er));
    chk({tag, ".ovf"}, 64'(res_ovf), 64'(eo));
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk({tag, ".vld0"}, 64'(res_valid), 64'd0);
    chk({tag, ".idle"}, 64'(start_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic [W-1:0] er;

    rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    start = 1'b0; x_in = '0; deg_in = '0; res_ready = 1'b0;
    for (int unsigned i = 0; i <= MAX_DEG; i++) cm[i] = '0;
    repeat (2) cyc();
    chk("rst.rdy", 64'(start_ready), 64'd1);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.vld", 64'(res_valid), 64'd0);
    chk("rst.data", 64'(res_data), 64'd0);
    chk("rst.ovf", 64'(res_ovf), 64'd0);
    rst_n = 1'b1;
    cyc();

    // T1
    wr(0, 1); wr(1, 2); wr(2, 3);
    eval("t1", 32'd4, 3'd2, 0, 0, '0, got);
    chk("t1.57", 64'(got), 64'd57);

    // T2: degree 0 and largest representable degree
    wr(0, 32'hDEAD);
    eval("t2.d0", $urandom, 3'd0, 0, 0, '0, got);
    chk("t2.dead", 64'(got), 64'hDEAD);
    for (int unsigned i = 0; i <= MAX_DEG; i++) wr(i, $urandom);
    eval("t2.dmax", $urandom, '1, 0, 0, '0, got);

    // T3: wrap to zero with overflow
    wr(1, 1); wr(0, 1);
    eval("t3", '1, 3'd1, 0, 0, '0, got);
    chk("t3.zero", 64'(got), 64'd0);

    for (int r = 0; r < 6; r++) begin
      for (int unsigned i = 0; i <= MAX_DEG; i++) wr(i, $urandom);
      eval("rnd", $urandom, DW'($urandom_range(0, MAX_DEG)), 0, 0, '0, got);
    end

    // write coincident with accept: old value used, new value kept
    x1 = $urandom;
    eval("wda.old", x1, 3'd3, 1, 2, $urandom, got);
    eval("wda.new", x1, 3'd3, 0, 0, '0, got);

    // T4: stall in DONE with start pulses and writes
    x1 = $urandom;
    er = poly(x1, 2);
    start = 1'b1; x_in = x1; deg_in = 3'd2;
    cyc();
    start = 1'b0;
    wait_valid("t4", 3);
    for (int c = 0; c < 10; c++) begin
      start = 1'b1; coef_we = 1'b1; coef_addr = 3'd0; coef_data = $urandom; x_in = $urandom;
      cyc();
      chk("t4.vld", 64'(res_valid), 64'd1);
      chk("t4.data", 64'(res_data), 64'(er));
    end
    start = 1'b0; coef_we = 1'b0;
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    eval("t4.keep", $urandom, 3'd0, 0, 0, '0, got);

    // T5: reset during RUN
    start = 1'b1; x_in = $urandom; deg_in = 3'd7;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("t5.rdy", 64'(start_ready), 64'd1);
    chk("t5.busy", 64'(busy), 64'd0);
    chk("t5.vld", 64'(res_valid), 64'd0);
    chk("t5.data", 64'(res_data), 64'd0);
    chk("t5.ovf", 64'(res_ovf), 64'd0);
    cyc();
    rst_n = 1'b1;
    for (int unsigned i = 0; i <= MAX_DEG; i++) cm[i] = '0;
    cyc();
    eval("t5.clr", $urandom, 3'd7, 0, 0, '0, got);
    chk("t5.zero", 64'(got), 64'd0);

    // T6: back-to-back
    for (int unsigned i = 0; i <= MAX_DEG; i++) wr(i, $urandom);
    x1 = $urandom;
    x2 = $urandom;
    start = 1'b1; res_ready = 1'b1; x_in = x1; deg_in = 3'd1;
    cyc();
    chk("t6.busy1", 64'(busy), 64'd1);
    wait_valid("t6.a", 2);
    chk("t6.data1", 64'(res_data), 64'(poly(x1, 1)));
    x_in = x2;
    cyc();
    chk("t6.hs.vld", 64'(res_valid), 64'd0);
    chk("t6.hs.rdy", 64'(start_ready), 64'd1);
    cyc();
    chk("t6.acc2", 64'(busy), 64'd1);
    chk("t6.rdy2", 64'(start_ready), 64'd0);
    start = 1'b0;
    wait_valid("t6.b", 2);
    chk("t6.data2", 64'(res_data), 64'(poly(x2, 1)));
    cyc();
    res_ready = 1'b0;
    chk("t6.end", 64'(start_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
